// File: rtl/clk_div_multi_if.sv
// Configuration and output bundle for clk_div_multi.
// The master side programs divide/phase values and observes the divided outputs;
// the divider itself connects through the slave modport.
interface clk_div_multi_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_phase;
  logic              cfg_apply;
  logic              cfg_pending;
  logic              locked;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] ce_out;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_phase, cfg_apply,
    input  cfg_pending, locked, clk_out, ce_out
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_phase, cfg_apply,
    output cfg_pending, locked, clk_out, ce_out
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel digital clock divider.
// Each channel owns a shadow/active divide+phase pair and a free-running counter.
// cfg_apply commits every shadow at once and realigns all counters, after which a
// settle window of LOCK_CYCLES refclk cycles passes before locked reasserts.
module clk_div_multi #(
  parameter int NUM_CH        = 2,
  parameter int DIV_W         = 8,
  parameter int DEF_DIV       = 4,
  parameter int LOCK_CYCLES   = 16,
  parameter int GATE_UNLOCKED = 1
) (
  input  logic               refclk,
  input  logic               reset,
  clk_div_multi_if.slave     bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);
  localparam logic [DIV_W-1:0] MIN_DIV     = DIV_W'(2);
  localparam logic [DIV_W-1:0] DEF_DIV_L   = DIV_W'(DEF_DIV);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);

  typedef enum logic {ST_SETTLE, ST_RUN} state_t;

  state_t            state_reg, state_next;
  logic [SET_W-1:0]  settle_reg, settle_next;
  logic              locked_int;
  logic              pending_reg;
  logic [DIV_W-1:0]  wr_div, wr_phase;
  logic [NUM_CH-1:0] clk_raw, ce_raw, diff;

  // Sanitise incoming configuration: ratio floors at 2, phase clamps to the last count.
  always_comb begin
    wr_div   = (bus.cfg_div < MIN_DIV) ? MIN_DIV : bus.cfg_div;
    wr_phase = (bus.cfg_phase >= wr_div) ? (wr_div - ONE) : bus.cfg_phase;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] shadow_div_reg, shadow_div_next;
      logic [DIV_W-1:0] shadow_phase_reg, shadow_phase_next;
      logic [DIV_W-1:0] active_div_reg, active_div_next;
      logic [DIV_W-1:0] active_phase_reg, active_phase_next;
      logic [DIV_W-1:0] cnt_reg, cnt_next;
      logic             clk_reg, ce_reg;
      logic             wr_hit;

      // An out-of-range cfg_ch matches no channel, so such writes fall away.
      assign wr_hit = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

      // Shadow capture, write-through commit on apply, and counter wrap/realign.
      always_comb begin
        shadow_div_next   = shadow_div_reg;
        shadow_phase_next = shadow_phase_reg;
        active_div_next   = active_div_reg;
        active_phase_next = active_phase_reg;
        cnt_next          = (cnt_reg >= active_div_reg - ONE) ? '0 : cnt_reg + ONE;
        if (wr_hit) begin
          shadow_div_next   = wr_div;
          shadow_phase_next = wr_phase;
        end
        if (bus.cfg_apply) begin
          active_div_next   = shadow_div_next;
          active_phase_next = shadow_phase_next;
          cnt_next          = shadow_phase_next;
        end
      end

      // Channel state and registered outputs decoded from the previous count.
      always_ff @(posedge refclk) begin
        if (reset) begin
          shadow_div_reg   <= DEF_DIV_L;
          shadow_phase_reg <= '0;
          active_div_reg   <= DEF_DIV_L;
          active_phase_reg <= '0;
          cnt_reg          <= '0;
          clk_reg          <= 1'b0;
          ce_reg           <= 1'b0;
        end else begin
          shadow_div_reg   <= shadow_div_next;
          shadow_phase_reg <= shadow_phase_next;
          active_div_reg   <= active_div_next;
          active_phase_reg <= active_phase_next;
          cnt_reg          <= cnt_next;
          clk_reg          <= (cnt_reg < (active_div_reg >> 1));
          ce_reg           <= (cnt_reg == active_div_reg - ONE);
        end
      end

      assign clk_raw[gi] = clk_reg;
      assign ce_raw[gi]  = ce_reg;
      assign diff[gi]    = (shadow_div_next != active_div_next) ||
                           (shadow_phase_next != active_phase_next);
    end
  endgenerate

  // Lock FSM state register.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_reg  <= ST_SETTLE;
      settle_reg <= '0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
    end
  end

  // Lock FSM next state: apply always restarts settling; settling ends after LOCK_CYCLES.
  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    locked_int  = (state_reg == ST_RUN);
    if (bus.cfg_apply) begin
      state_next  = ST_SETTLE;
      settle_next = '0;
    end else begin
      case (state_reg)
        ST_SETTLE: begin
          if (settle_reg == SETTLE_LAST) begin
            state_next  = ST_RUN;
            settle_next = '0;
          end else begin
            settle_next = settle_reg + SET_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Pending flag tracks shadow/active disagreement one cycle after it arises.
  always_ff @(posedge refclk) begin
    if (reset) pending_reg <= 1'b0;
    else       pending_reg <= |diff;
  end

  assign bus.cfg_pending = pending_reg;
  assign bus.locked      = locked_int;
  assign bus.clk_out     = (GATE_UNLOCKED != 0) ? (clk_raw & {NUM_CH{locked_int}}) : clk_raw;
  assign bus.ce_out      = (GATE_UNLOCKED != 0) ? (ce_raw & {NUM_CH{locked_int}}) : ce_raw;
endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: a spec-level model of each channel
// predicts locked/pending/clk_out/ce_out per cycle since the last alignment;
// predictions are queued on stimulus and popped against the DUT every cycle.
module tb_clk_div_multi;
  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 8;
  localparam int DEF_DIV     = 4;
  localparam int LOCK_CYCLES = 16;
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic refclk = 1'b0;
  logic reset  = 1'b1;

  clk_div_multi_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  clk_div_multi #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV),
    .LOCK_CYCLES(LOCK_CYCLES), .GATE_UNLOCKED(1)
  ) dut (
    .refclk(refclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic              locked;
    logic              pending;
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] ce;
  } obs_t;

  obs_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   act_div[NUM_CH];
  int   act_ph [NUM_CH];
  int   sh_div [NUM_CH];
  int   sh_ph  [NUM_CH];
  int   align_j = 0;

  function automatic logic model_pending();
    logic p = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (sh_div[c] != act_div[c] || sh_ph[c] != act_ph[c]) p = 1'b1;
    return p;
  endfunction

  // Expected outputs j cycles after alignment (cycle where every cnt == phase).
  function automatic obs_t model(int j);
    obs_t e;
    int   k;
    e.locked  = (j >= LOCK_CYCLES);
    e.pending = model_pending();
    e.clk     = '0;
    e.ce      = '0;
    if (e.locked) begin
      for (int c = 0; c < NUM_CH; c++) begin
        k = (act_ph[c] + j - 1) % act_div[c];
        e.clk[c] = (k < act_div[c] / 2);
        e.ce[c]  = (k == act_div[c] - 1);
      end
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.locked  = bus.locked;
    o.pending = bus.cfg_pending;
    o.clk     = bus.clk_out;
    o.ce      = bus.ce_out;
    return o;
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
    align_j++;
  endtask

  task automatic push_window(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(model(align_j + i));
  endtask

  task automatic model_write(input int ch, input int dv, input int ph);
    int d;
    d = (dv < 2) ? 2 : dv;
    sh_div[ch] = d;
    sh_ph[ch]  = (ph >= d) ? d - 1 : ph;
  endtask

  task automatic do_write(input int ch, input int dv, input int ph);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = CH_W'(ch);
    bus.cfg_div   = DIV_W'(dv);
    bus.cfg_phase = DIV_W'(ph);
    model_write(ch, dv, ph);
    $display("txn write ch=%0d div=%0d phase=%0d", ch, dv, ph);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_apply();
    bus.cfg_apply = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      act_div[c] = sh_div[c];
      act_ph[c]  = sh_ph[c];
    end
    $display("txn apply divs=%0d,%0d phases=%0d,%0d", act_div[0], act_div[1], act_ph[0], act_ph[1]);
    tick();
    bus.cfg_apply = 1'b0;
    align_j = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      act_div[c] = DEF_DIV; act_ph[c] = 0;
      sh_div[c]  = DEF_DIV; sh_ph[c]  = 0;
    end
    align_j = 0;
    $display("txn reset cycles=%0d", n);
  endtask

  task automatic test_reset();
    obs_t e, o;
    do_reset(3);
    push_window(LOCK_CYCLES + 12);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_win j=%0d got=%b want=%b", align_j, o, e);
      end
      tick();
    end
  endtask

  task automatic test_phase();
    obs_t e, o;
    do_write(1, 4, 1);
    checks++;
    if (bus.cfg_pending !== 1'b1) begin
      failures++;
      $display("FAIL phase_pending got=%b want=1", bus.cfg_pending);
    end
    do_apply();
    push_window(LOCK_CYCLES + 12);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL phase_win j=%0d got=%b want=%b", align_j, o, e);
      end
      tick();
    end
  endtask

  task automatic test_odd_div();
    obs_t e, o;
    do_write(0, 5, 0);
    do_apply();
    push_window(LOCK_CYCLES + 15);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL odd_win j=%0d got=%b want=%b", align_j, o, e);
      end
      tick();
    end
  endtask

  task automatic test_sanitize();
    obs_t e, o;
    do_write(0, 0, 0);
    do_write(1, 4, 7);
    do_apply();
    push_window(LOCK_CYCLES + 8);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL sanitize_win j=%0d got=%b want=%b", align_j, o, e);
      end
      tick();
    end
  endtask

  task automatic test_write_through();
    obs_t e, o;
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = CH_W'(0);
    bus.cfg_div   = DIV_W'(6);
    bus.cfg_phase = DIV_W'(0);
    model_write(0, 6, 0);
    $display("txn write ch=0 div=6 phase=0 (with apply)");
    do_apply();
    bus.cfg_we = 1'b0;
    push_window(LOCK_CYCLES + 12);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wthru_win j=%0d got=%b want=%b", align_j, o, e);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    do_apply();
    push_window(5);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_first j=%0d got=%b want=%b", align_j, o, e);
      end
      tick();
    end
    do_apply();
    push_window(LOCK_CYCLES + 6);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_second j=%0d got=%b want=%b", align_j, o, e);
      end
      tick();
    end
  endtask

  task automatic test_reset_pending();
    obs_t e, o;
    do_write(1, 7, 2);
    checks++;
    if (bus.cfg_pending !== 1'b1) begin
      failures++;
      $display("FAIL rstpend_pending got=%b want=1", bus.cfg_pending);
    end
    do_reset(1);
    push_window(LOCK_CYCLES + 8);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rstpend_win j=%0d got=%b want=%b", align_j, o, e);
      end
      tick();
    end
    do_apply();
    push_window(LOCK_CYCLES + 8);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rstpend_apply j=%0d got=%b want=%b", align_j, o, e);
      end
      tick();
    end
  endtask

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_div   = '0;
    bus.cfg_phase = '0;
    bus.cfg_apply = 1'b0;
    test_reset();
    test_phase();
    test_odd_div();
    test_sanitize();
    test_write_through();
    test_back_to_back();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
